// File: rtl/btn_num_ctrl.sv
// btn_num_ctrl
//   Front end for the 4-nibble hex number editor. Each raw push-button goes
//   through a 2-FF synchronizer and its own debounce FSM. Each accepted press
//   produces a one-cycle pulse that steps the matching nibble of num up or down.
// Ports
//   clk        : system clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   btn[3:0]   : raw asynchronous buttons, active-high; btn[i] steps num[4i+3:4i]
//   dir        : raw switch, 0 = increment, 1 = decrement (synchronized only)
//   clr        : clean synchronous clear, takes priority over step pulses
//   num[15:0]  : held number, four independent modulo-16 nibbles
//   step_valid : one-cycle flag, at least one nibble stepped on the previous edge
//   step_idx   : mask of the nibbles stepped, zero when step_valid is low
module btn_num_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic        dir,
  input  logic        clr,
  output logic [15:0] num,
  output logic        step_valid,
  output logic [3:0]  step_idx
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchronizers
  logic [3:0] btn_meta_q, btn_meta_d;
  logic [3:0] btn_s_q,    btn_s_d;
  logic       dir_meta_q, dir_meta_d;
  logic       dir_s_q,    dir_s_d;

  // Debounce FSMs, one per button
  db_state_e        state_q [4];
  db_state_e        state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       press;

  // Number datapath
  logic [15:0] num_q, num_d;
  logic        step_valid_q, step_valid_d;
  logic [3:0]  step_idx_q, step_idx_d;

  always_comb begin
    btn_meta_d = btn;
    btn_s_d    = btn_meta_q;
    dir_meta_d = dir;
    dir_s_d    = dir_meta_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q   <= '0;
      btn_s_q      <= '0;
      dir_meta_q   <= 1'b0;
      dir_s_q      <= 1'b0;
      num_q        <= '0;
      step_valid_q <= 1'b0;
      step_idx_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      btn_meta_q   <= btn_meta_d;
      btn_s_q      <= btn_s_d;
      dir_meta_q   <= dir_meta_d;
      dir_s_q      <= dir_s_d;
      num_q        <= num_d;
      step_valid_q <= step_valid_d;
      step_idx_q   <= step_idx_d;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (btn_s_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!btn_s_q[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_s_q[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = CNT_ONE;
          end
        end
        RELEASE_CHK: begin
          if (btn_s_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic: the press pulse is the cycle in which PRESS_CHK accepts
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      press[i] = (state_q[i] == PRESS_CHK) && btn_s_q[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  // Nibble update; clr discards any pulse landing on the same edge
  always_comb begin
    num_d      = num_q;
    step_idx_d = '0;
    if (!clr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (press[i]) begin
          num_d[4*i +: 4] = dir_s_q ? (num_q[4*i +: 4] - 4'd1) : (num_q[4*i +: 4] + 4'd1);
          step_idx_d[i]   = 1'b1;
        end
      end
    end else begin
      num_d = '0;
    end
    step_valid_d = |step_idx_d;
  end

  assign num        = num_q;
  assign step_valid = step_valid_q;
  assign step_idx   = step_idx_q;

endmodule

// File: tb/tb_btn_num_ctrl.sv
module tb_btn_num_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = '0;
  logic        dir = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] num;
  logic        step_valid;
  logic [3:0]  step_idx;

  int tests = 0;
  int fails = 0;

  // Reference model: accepted level per button flips after D+1 consecutive
  // opposite samples of the synchronized input, which lags the pin by 2 edges.
  int          run [4];
  bit          acc [4];
  logic [3:0]  h1, h2;
  logic        d1, d2;
  logic [15:0] m_num;
  logic        m_sv;
  logic [3:0]  m_idx;

  btn_num_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .dir        (dir),
    .clr        (clr),
    .num        (num),
    .step_valid (step_valid),
    .step_idx   (step_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] bs, prs;
    logic       ds;
    logic [3:0] nib;
    if (rst) begin
      h1 = '0; h2 = '0; d1 = 1'b0; d2 = 1'b0;
      m_num = '0; m_sv = 1'b0; m_idx = '0;
      for (int i = 0; i < 4; i++) begin
        run[i] = 0;
        acc[i] = 1'b0;
      end
    end else begin
      bs = h2; ds = d2;
      h2 = h1; h1 = btn;
      d2 = d1; d1 = dir;
      prs = '0;
      for (int i = 0; i < 4; i++) begin
        if (bs[i] != acc[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            acc[i] = ~acc[i];
            run[i] = 0;
            prs[i] = acc[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      if (clr) begin
        m_num = '0; m_sv = 1'b0; m_idx = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (prs[i]) begin
            nib = m_num[i*4 +: 4];
            nib = ds ? nib - 4'd1 : nib + 4'd1;
            m_num[i*4 +: 4] = nib;
          end
        end
        m_idx = prs;
        m_sv  = |prs;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_num", num, m_num);
    check("model_step_valid", 16'(step_valid), 16'(m_sv));
    check("model_step_idx", 16'(step_idx), 16'(m_idx));
  endtask

  task automatic press_btn(input int i);
    btn[i] = 1'b1;
    repeat (8) tick();
    btn[i] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int          t_seen, pulses, hcnt [4];
    logic [15:0] prev;
    logic [11:0] low;

    // 1: reset, then single press of btn[0]
    rst = 1'b1;
    tick(); tick();
    check("reset_num", num, 16'h0000);
    check("reset_step_valid", 16'(step_valid), 16'h0);
    check("reset_step_idx", 16'(step_idx), 16'h0);
    rst = 1'b0;
    btn = 4'b0001;
    t_seen = -1; pulses = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (step_valid) begin
        pulses++;
        check("t1_idx", 16'(step_idx), 16'h0001);
      end
      if (t_seen < 0 && num == 16'h0001) t_seen = t;
    end
    check("t1_latency", 16'(t_seen), 16'd6);
    check("t1_pulses", 16'(pulses), 16'd1);
    check("t1_num", num, 16'h0001);
    btn = '0;
    repeat (10) tick();

    // 2: bounce on btn[1] then steady
    pulses = 0;
    btn = 4'b0010; tick(); if (step_valid) pulses++;
    btn = 4'b0000; tick(); if (step_valid) pulses++;
    btn = 4'b0010; tick(); if (step_valid) pulses++;
    btn = 4'b0000; tick(); if (step_valid) pulses++;
    btn = 4'b0010;
    t_seen = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (step_valid) pulses++;
      if (t_seen < 0 && num[7:4] == 4'h1) t_seen = t;
    end
    check("t2_latency", 16'(t_seen), 16'd6);
    check("t2_pulses", 16'(pulses), 16'd1);
    check("t2_num", num, 16'h0011);
    btn = '0;
    repeat (10) tick();

    // 3: wrap F->0 on increment, 0->F on decrement
    for (int k = 0; k < 15; k++) press_btn(3);
    check("t3_preload", num, 16'hF011);
    low = num[11:0];
    press_btn(3);
    check("t3_wrap_up", 16'(num[15:12]), 16'h0);
    check("t3_low_kept", 16'(num[11:0]), 16'(low));
    dir = 1'b1;
    repeat (4) tick();
    press_btn(3);
    check("t3_wrap_down", num, 16'hF011);
    dir = 1'b0;
    repeat (4) tick();

    // 4: all four buttons on the same edge from 1234
    clr = 1'b1; tick(); clr = 1'b0;
    check("t4_clr", num, 16'h0000);
    press_btn(3);
    repeat (2) press_btn(2);
    repeat (3) press_btn(1);
    repeat (4) press_btn(0);
    check("t4_preload", num, 16'h1234);
    btn = 4'b1111;
    pulses = 0;
    prev = num;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (step_valid) begin
        pulses++;
        check("t4_idx", 16'(step_idx), 16'h000F);
        check("t4_before", prev, 16'h1234);
        check("t4_after", num, 16'h2345);
      end
      prev = num;
    end
    check("t4_pulses", 16'(pulses), 16'd1);
    btn = '0;
    repeat (10) tick();

    // 5: clr on the exact pulse cycle of btn[2]
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (10) press_btn(1);
    check("t5_preload", num, 16'h00A0);
    btn = 4'b0100;
    pulses = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (step_valid) pulses++;
    end
    clr = 1'b1; tick(); clr = 1'b0;
    if (step_valid) pulses++;
    check("t5_cleared", num, 16'h0000);
    for (int t = 0; t < 10; t++) begin
      tick();
      if (step_valid) pulses++;
    end
    check("t5_no_step", 16'(pulses), 16'd0);
    check("t5_held", num, 16'h0000);
    btn = '0;
    repeat (10) tick();
    press_btn(2);
    check("t5_repress", num, 16'h0100);

    // 6: reset while btn[0] held in PRESSED
    btn = 4'b0001;
    repeat (10) tick();
    check("t6_pre", num, 16'h0101);
    rst = 1'b1; tick(); tick();
    check("t6_reset", num, 16'h0000);
    rst = 1'b0;
    t_seen = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t_seen < 0 && num == 16'h0001) t_seen = t;
    end
    check("t6_latency", 16'(t_seen), 16'd6);
    check("t6_num", num, 16'h0001);
    btn = '0;
    repeat (10) tick();

    // Random phase: mixed bounces and long holds, dir flips, clr and rst
    for (int i = 0; i < 4; i++) hcnt[i] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (hcnt[i] == 0) begin
          btn[i]  = ~btn[i];
          hcnt[i] = int'($urandom_range(1, 12));
        end else begin
          hcnt[i]--;
        end
      end
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
